// File: rtl/scan_pkg.sv
// Shared types and constants for the scan select sequencer.
package scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 16;

  // Dwell/blank cycle counter
  typedef logic [CNT_W-1:0] cnt_t;

  // Enumerators carry a prefix so they never collide with the DWELL/BLANK parameters
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_sel_gen_if.sv
// Control and select bundle between a scan controller and scan_sel_gen.
interface scan_sel_gen_if;
  import scan_pkg::*;

  logic              en;
  logic [NUM_CH-1:0] chan_mask;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;
  logic              frame_done;
  logic              busy;

  modport master (
    output en,
    output chan_mask,
    input  sel,
    input  sel_valid,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  en,
    input  chan_mask,
    output sel,
    output sel_valid,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/scan_sel_gen_next_chan_find.sv
// Combinational next-channel search: smallest set mask bit strictly above cur,
// otherwise the smallest set bit overall with wrap raised.
module next_chan_find
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic [SEL_W-1:0]  lowest
);

  logic found_low;
  logic found_hi;

  // Priority scan from bit 0 upward for both the lowest and the next-above set bit
  always_comb begin
    lowest    = '0;
    nxt       = '0;
    found_low = 1'b0;
    found_hi  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (mask[SEL_W'(i)] && !found_low) begin
        lowest    = SEL_W'(i);
        found_low = 1'b1;
      end
      if (mask[SEL_W'(i)] && !found_hi && (SEL_W'(i) > cur)) begin
        nxt      = SEL_W'(i);
        found_hi = 1'b1;
      end
    end
    if (!found_hi) begin
      nxt = lowest;
    end
    wrap = !found_hi;
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Channel select sequencer feeding a 3-to-8 one-hot decoder. Walks the enabled
// channels of chan_mask in ascending order, holding each for DWELL cycles.
// Optional macro SCAN_BLANK_EN inserts BLANK cycles with sel_valid low between
// consecutive channels.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 16,
  parameter int unsigned BLANK = 2
) (
  input logic           clk,
  input logic           rst,
  scan_sel_gen_if.slave bus
);

  localparam cnt_t DWELL_LAST = cnt_t'(DWELL - 1);
`ifdef SCAN_BLANK_EN
  localparam cnt_t BLANK_LAST = cnt_t'(BLANK - 1);
`else
  localparam int unsigned unused_blank = BLANK;
`endif

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  cnt_t              cnt_q, cnt_d;
`ifdef SCAN_BLANK_EN
  logic [SEL_W-1:0]  pend_q, pend_d;
`endif

  logic [SEL_W-1:0]  cur_nxt;
  logic              cur_wrap;
  logic [SEL_W-1:0]  new_lowest;
  logic [SEL_W-1:0]  next_idx;
  logic              go_on;

  logic [SEL_W-1:0]  unused_cur_lowest;
  logic [SEL_W-1:0]  unused_new_nxt;
  logic              unused_new_wrap;

  // Successor of the held channel within the latched mask
  next_chan_find u_cur_find (
    .mask   (mask_q),
    .cur    (sel_q),
    .nxt    (cur_nxt),
    .wrap   (cur_wrap),
    .lowest (unused_cur_lowest)
  );

  // First channel of a freshly sampled mask (frame start)
  next_chan_find u_new_find (
    .mask   (bus.chan_mask),
    .cur    ('0),
    .nxt    (unused_new_nxt),
    .wrap   (unused_new_wrap),
    .lowest (new_lowest)
  );

  // Next-state logic for the scan sequencer
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    next_idx = cur_nxt;
    go_on    = 1'b1;
`ifdef SCAN_BLANK_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.chan_mask != '0)) begin
          mask_d  = bus.chan_mask;
          sel_d   = new_lowest;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (cur_wrap) begin
            // Frame boundary: only here are en and chan_mask resampled
            done_d   = 1'b1;
            next_idx = new_lowest;
            if (!bus.en || (bus.chan_mask == '0)) begin
              go_on   = 1'b0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              mask_d = bus.chan_mask;
            end
          end
          if (go_on) begin
`ifdef SCAN_BLANK_EN
            valid_d = 1'b0;
            pend_d  = next_idx;
            state_d = ST_BLANK;
`else
            sel_d   = next_idx;
`endif
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          sel_d   = pend_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_DWELL;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
`ifdef SCAN_BLANK_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
`ifdef SCAN_BLANK_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen with DWELL=4, BLANK=2. Expected per-cycle
// output tuples {sel, sel_valid, frame_done, busy} are queued as each scenario
// is set up and popped on every falling clock edge.
module tb_scan_sel_gen;

  localparam int unsigned DW = 4;
`ifdef SCAN_BLANK_EN
  localparam int unsigned BLK = 2;
`else
  localparam int unsigned BLK = 0;
`endif
  localparam int unsigned PER = DW + BLK;

  logic clk;
  logic rst;

  scan_sel_gen_if bus ();

  scan_sel_gen #(
    .DWELL (4),
    .BLANK (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] exp_q[$];
  logic       pend_done;
  int         vectors;
  int         miscompares;

  function automatic logic [5:0] observed();
    return {bus.sel, bus.sel_valid, bus.frame_done, bus.busy};
  endfunction

  task automatic push_cyc(input logic [2:0] s, input logic v, input logic b);
    exp_q.push_back({s, v, pend_done, b});
    pend_done = 1'b0;
  endtask

  // One channel: DWELL valid cycles, then blank cycles unless the scan stops here
  task automatic push_chan(input logic [2:0] c, input logic last, input logic to_idle);
    for (int i = 0; i < int'(DW); i++) push_cyc(c, 1'b1, 1'b1);
    if (last) pend_done = 1'b1;
    if (!to_idle) begin
      for (int i = 0; i < int'(BLK); i++) push_cyc(c, 1'b0, 1'b1);
    end
  endtask

  task automatic push_idle(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) push_cyc(s, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string tag, input logic [5:0] exp_v);
    logic [5:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed {sel,vld,done,busy}=%b required %b at %0t", tag, obs, exp_v,
             $time);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: scoreboard empty, observed %b required an entry", tag, observed());
      end else begin
        check_now(tag, exp_q.pop_front());
      end
    end
  endtask

  task automatic run_all(input string tag);
    run(tag, exp_q.size());
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    pend_done     = 1'b0;
    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.chan_mask = '0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check_now("reset_async", 6'b000_0_0_0);
    @(negedge clk);
    rst = 1'b0;

    // Mask 1000_0101: 0,2,7 per frame; en drops mid second frame
    bus.en = 1'b1;
    bus.chan_mask = 8'b1000_0101;
    push_chan(3'd0, 1'b0, 1'b0);
    push_chan(3'd2, 1'b0, 1'b0);
    push_chan(3'd7, 1'b1, 1'b0);
    push_chan(3'd0, 1'b0, 1'b0);
    push_chan(3'd2, 1'b0, 1'b0);
    push_chan(3'd7, 1'b1, 1'b1);
    push_idle(3'd7, 3);
    run("mask85", 3 * PER + 2);
    bus.en = 1'b0;
    run_all("mask85_stop");

    // Single channel: sel fixed at 4, frame_done once per period
    bus.en = 1'b1;
    bus.chan_mask = 8'h10;
    push_chan(3'd4, 1'b1, 1'b0);
    push_chan(3'd4, 1'b1, 1'b0);
    push_chan(3'd4, 1'b1, 1'b1);
    push_idle(3'd4, 2);
    run("mask10", 2 * PER + 1);
    bus.en = 1'b0;
    run_all("mask10_stop");

    // Mask change 0F->F0 while sel=1 takes effect at the next frame
    bus.en = 1'b1;
    bus.chan_mask = 8'h0F;
    push_chan(3'd0, 1'b0, 1'b0);
    push_chan(3'd1, 1'b0, 1'b0);
    push_chan(3'd2, 1'b0, 1'b0);
    push_chan(3'd3, 1'b1, 1'b0);
    push_chan(3'd4, 1'b0, 1'b0);
    push_chan(3'd5, 1'b0, 1'b0);
    push_chan(3'd6, 1'b0, 1'b0);
    push_chan(3'd7, 1'b1, 1'b1);
    push_idle(3'd7, 2);
    run("mask_chg", PER + 1);
    bus.chan_mask = 8'hF0;
    run("mask_chg", 3 * PER);
    bus.en = 1'b0;
    run_all("mask_chg_stop");

    // en dropped while sel=1: frame completes, sel held at 3
    bus.en = 1'b1;
    bus.chan_mask = 8'h0F;
    push_chan(3'd0, 1'b0, 1'b0);
    push_chan(3'd1, 1'b0, 1'b0);
    push_chan(3'd2, 1'b0, 1'b0);
    push_chan(3'd3, 1'b1, 1'b1);
    push_idle(3'd3, 3);
    run("en_drop", PER + 1);
    bus.en = 1'b0;
    run_all("en_drop_tail");

    // Empty mask with en=1 never starts
    bus.en = 1'b1;
    bus.chan_mask = 8'h00;
    push_idle(3'd3, 3);
    run_all("mask_zero");

    // Full mask: 0..7, frame_done after channel 7
    bus.chan_mask = 8'hFF;
    for (int c = 0; c < 8; c++) push_chan(3'(c), (c == 7), (c == 7));
    push_idle(3'd7, 2);
    run("mask_ff", 1);
    bus.en = 1'b0;
    run_all("mask_ff");

    // Reset mid-scan clears outputs at once, then scan restarts from IDLE
    bus.en = 1'b1;
    bus.chan_mask = 8'h05;
    push_cyc(3'd0, 1'b1, 1'b1);
    push_cyc(3'd0, 1'b1, 1'b1);
    push_cyc(3'd0, 1'b1, 1'b1);
    run("pre_reset", 3);
    #2 rst = 1'b1;
    #1 check_now("reset_mid", 6'b000_0_0_0);
    @(negedge clk);
    check_now("reset_held", 6'b000_0_0_0);
    rst = 1'b0;
    push_chan(3'd0, 1'b0, 1'b0);
    push_chan(3'd2, 1'b1, 1'b1);
    push_idle(3'd2, 2);
    run("restart", 1);
    bus.en = 1'b0;
    run_all("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
